// File: rtl/sample_dma_pkg.sv
// Shared definitions for sample_dma: register offsets, CTRL/STATUS bit
// positions, FSM state encoding and the saturating counter helper.
package sample_dma_pkg;

   localparam logic [4:0] SDMA_CTRL   = 5'h00;
   localparam logic [4:0] SDMA_BASE   = 5'h04;
   localparam logic [4:0] SDMA_LIMIT  = 5'h08;
   localparam logic [4:0] SDMA_PTR    = 5'h0C;
   localparam logic [4:0] SDMA_COUNT  = 5'h10;
   localparam logic [4:0] SDMA_STATUS = 5'h14;

   localparam int CTRL_EN   = 0;
   localparam int CTRL_WRAP = 1;
   localparam int CTRL_CLR  = 2;

   localparam int STAT_BUSY    = 0;
   localparam int STAT_DONE    = 1;
   localparam int STAT_WRAPPED = 2;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_WRITE = 1'b1
   } dma_state_t;

   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

endpackage

// File: rtl/sample_dma.sv
// Drains the FWFT sample FIFO into SDRAM through the write channel, one
// 16-bit sample per word address, in linear (stop at LIMIT) or ring mode.
module sample_dma
   import sample_dma_pkg::*;
#(
   parameter int AW = 24,
   parameter int DW = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          fifo_empty,
   input  logic [DW-1:0] fifo_data,
   output logic          fifo_rd,
   output logic [AW-1:0] awaddr,
   output logic [DW-1:0] wdata,
   output logic          wvalid,
   input  logic          wready,
   input  logic [4:0]    cfg_addr,
   input  logic [31:0]   cfg_wdata,
   input  logic          cfg_wvalid,
   output logic [31:0]   cfg_rdata,
   output logic          busy
);

   dma_state_t    state_reg, state_next;

   logic          enable_reg;
   logic          wrap_reg;
   logic          done_reg;
   logic          wrapped_reg;
   logic [AW-1:0] base_reg;
   logic [AW-1:0] limit_reg;
   logic [AW-1:0] ptr_reg;
   logic [31:0]   count_reg;
   logic [AW-1:0] awaddr_reg;
   logic [DW-1:0] wdata_reg;

   logic          cfg_wr_ctrl;
   logic          enable_rise;
   logic          w1c_clear;
   logic          accept;
   logic [AW-1:0] ptr_inc;
   logic          at_limit;
   logic          hit_done;
   logic          hit_wrap;
   logic          done_after;
   logic [AW-1:0] ptr_after;
   logic          pop;
   logic          unused_cfg;

   assign unused_cfg  = ^cfg_wdata[31:AW];

   assign cfg_wr_ctrl = cfg_wvalid && (cfg_addr == SDMA_CTRL);
   assign enable_rise = cfg_wr_ctrl && cfg_wdata[CTRL_EN] && !enable_reg;
   assign w1c_clear   = cfg_wr_ctrl && cfg_wdata[CTRL_CLR];

   // Pointer advance happens only on a completed handshake; LIMIT is exclusive.
   assign accept      = (state_reg == ST_WRITE) && wready;
   assign ptr_inc     = ptr_reg + AW'(1);
   assign at_limit    = (ptr_inc == limit_reg);
   assign hit_done    = accept && at_limit && !wrap_reg;
   assign hit_wrap    = accept && at_limit && wrap_reg;
   assign done_after  = done_reg || hit_done;

   always_comb begin
      ptr_after = ptr_reg;
      if (accept) begin
         if (hit_wrap)
            ptr_after = base_reg;
         else
            ptr_after = ptr_inc;
      end
   end

   // FSM state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state_reg <= ST_IDLE;
      else
         state_reg <= state_next;
   end

   // FSM next state and pop strobe
   always_comb begin
      state_next = state_reg;
      pop        = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (enable_reg && !done_reg && !fifo_empty) begin
               pop        = 1'b1;
               state_next = ST_WRITE;
            end
         end
         ST_WRITE: begin
            if (accept) begin
               if (enable_reg && !done_after && !fifo_empty)
                  pop = 1'b1;
               else
                  state_next = ST_IDLE;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // Write channel holding registers; only loaded on a pop.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         awaddr_reg <= '0;
         wdata_reg  <= '0;
      end else if (pop) begin
         awaddr_reg <= ptr_after;
         wdata_reg  <= fifo_data;
      end
   end

   // Register bank
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         enable_reg  <= 1'b0;
         wrap_reg    <= 1'b0;
         done_reg    <= 1'b0;
         wrapped_reg <= 1'b0;
         base_reg    <= '0;
         limit_reg   <= '0;
         ptr_reg     <= '0;
         count_reg   <= '0;
      end else begin
         if (cfg_wr_ctrl) begin
            enable_reg <= cfg_wdata[CTRL_EN];
            wrap_reg   <= cfg_wdata[CTRL_WRAP];
         end
         // Window bounds are frozen while a capture is enabled.
         if (cfg_wvalid && !enable_reg) begin
            if (cfg_addr == SDMA_BASE)
               base_reg <= cfg_wdata[AW-1:0];
            if (cfg_addr == SDMA_LIMIT)
               limit_reg <= cfg_wdata[AW-1:0];
         end

         if (enable_rise) begin
            ptr_reg   <= base_reg;
            count_reg <= '0;
         end else begin
            ptr_reg <= ptr_after;
            if (accept)
               count_reg <= sat_inc(count_reg);
         end

         // Hardware set beats a W1C clear landing in the same cycle.
         if (enable_rise)
            done_reg <= (limit_reg <= base_reg);
         else if (hit_done)
            done_reg <= 1'b1;
         else if (w1c_clear)
            done_reg <= 1'b0;

         if (enable_rise)
            wrapped_reg <= 1'b0;
         else if (hit_wrap)
            wrapped_reg <= 1'b1;
         else if (w1c_clear)
            wrapped_reg <= 1'b0;
      end
   end

   always_comb begin
      cfg_rdata = '0;
      case (cfg_addr)
         SDMA_CTRL:   cfg_rdata = {30'd0, wrap_reg, enable_reg};
         SDMA_BASE:   cfg_rdata = 32'(base_reg);
         SDMA_LIMIT:  cfg_rdata = 32'(limit_reg);
         SDMA_PTR:    cfg_rdata = 32'(ptr_reg);
         SDMA_COUNT:  cfg_rdata = count_reg;
         SDMA_STATUS: cfg_rdata = {29'd0, wrapped_reg, done_reg, (state_reg == ST_WRITE)};
         default:     cfg_rdata = '0;
      endcase
   end

   assign fifo_rd = pop;
   assign awaddr  = awaddr_reg;
   assign wdata   = wdata_reg;
   assign wvalid  = (state_reg == ST_WRITE);
   assign busy    = (state_reg == ST_WRITE);

endmodule
